gearbox_arbiter: RTL

Round-robin write-side scheduler for the 16-to-20-bit gearbox. It shares the gearbox's single 16-bit input port among up to eight producers. Each grant is an atomic burst of BURST_LEN words, by default five 16-bit words, which is one 80-bit frame or four 20-bit output words, so the gearbox output never mixes sources within a 20-bit word. A stalled owner is finished off with zero padding after a timeout, which keeps frame alignment intact.

---
 rtl/gearbox_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/gearbox_arbiter.sv
// Round-robin write-side scheduler for the 16-to-20-bit gearbox: grants atomic
// BURST_LEN-word bursts and zero-pads frames whose owner stalls too long.
module gearbox_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 5,
  parameter int TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   res_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  data_in,
  output logic [NUM_REQ-1:0]     ack,
  output logic [NUM_REQ-1:0]     grant,
  output logic [2:0]             owner_id,
  input  logic                   gb_full,
  output logic                   gb_shift_in,
  output logic [15:0]            gb_data_in,
  output logic                   frame_done,
  output logic                   timeout,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, PAD = 2'd2} state_e;

  localparam logic [3:0] CNT_LAST = 4'(BURST_LEN - 1);
  localparam logic [7:0] STL_LAST = 8'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [2:0]           owner_q, owner_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [7:0]           stl_q, stl_d;
  logic                 timeout_q, timeout_d;

  logic [2:0]           win_hi, win_lo, win_id;
  logic                 any_hi, any_req;
  logic [NUM_REQ-1:0]   win_oh;
  logic                 owner_req, xfer;
  logic [15:0]          owner_data;

  // Winner is the lowest requester above owner_q, else the lowest overall,
  // which leaves owner_q itself with the lowest priority.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    win_hi = '0;
    win_lo = '0;
    any_hi = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_lo = 3'(i);
        if (3'(i) > owner_q) begin
          win_hi = 3'(i);
          any_hi = 1'b1;
        end
      end
    end
    win_id  = any_hi ? win_hi : win_lo;
    any_req = |req;
    for (int i = 0; i < NUM_REQ; i++) win_oh[i] = (3'(i) == win_id);
  end

  always_comb begin
    owner_req  = |(req & grant_q);
    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) owner_data = data_in[16*i +: 16];
    end
  end

  assign xfer = (state_q == BURST) && owner_req && !gb_full;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    stl_d       = stl_q;
    timeout_d   = 1'b0;
    ack         = '0;
    gb_shift_in = 1'b0;
    gb_data_in  = '0;
    frame_done  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = win_oh;
          owner_d = win_id;
          cnt_d   = '0;
          stl_d   = '0;
          state_d = BURST;
        end
      end

      BURST: begin
        if (xfer) begin
          gb_shift_in = 1'b1;
          gb_data_in  = owner_data;
          ack         = grant_q;
          stl_d       = '0;
          if (cnt_q == CNT_LAST) begin
            frame_done = 1'b1;
            cnt_d      = '0;
            if (any_req) begin
              grant_d = win_oh;
              owner_d = win_id;
            end else begin
              grant_d = '0;
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else if (!gb_full) begin
          if (stl_q == STL_LAST) begin
            grant_d   = '0;
            timeout_d = 1'b1;
            state_d   = PAD;
          end else begin
            stl_d = stl_q + 8'd1;
          end
        end
      end

      PAD: begin
        if (!gb_full) begin
          gb_shift_in = 1'b1;
          if (cnt_q == CNT_LAST) begin
            frame_done = 1'b1;
            cnt_d      = '0;
            state_d    = IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Reset restarts arbitration at requester 0 and abandons any partial frame.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= 3'(NUM_REQ - 1);
      cnt_q     <= '0;
      stl_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      stl_q     <= stl_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant    = grant_q;
  assign owner_id = owner_q;
  assign timeout  = timeout_q;
  assign busy     = (state_q != IDLE);

endmodule
